div_seq_ctrl: RTL and testbench



---
 rtl/div_seq_ctrl.sv | 109 ++++++++++
 tb/tb_div_seq_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/div_seq_ctrl.sv
// Sequencing controller for the EX-stage iterative divider: radix-2 restoring
// divide, one quotient bit per cycle, with signed fix-up, divide-by-zero and annul.
module div_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] opa_i,
    input  logic [WIDTH-1:0] opb_i,
    input  logic             annul_i,
    output logic             stall_o,
    output logic             ready_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             dz_o
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] rem_q, quo_q, dvs_q, hi_q, lo_q;
    logic             qneg_q, rneg_q, ready_q, dz_q;

    logic [WIDTH-1:0] mag_a, mag_b, rem_d, quo_d;
    logic [WIDTH:0]   shift_w, trial_w;

    always_comb begin
        mag_a   = (signed_i && opa_i[WIDTH-1]) ? -opa_i : opa_i;
        mag_b   = (signed_i && opb_i[WIDTH-1]) ? -opb_i : opb_i;
        // Shifted remainder needs one extra bit: it can reach 2*divisor-1.
        shift_w = {rem_q, quo_q[WIDTH-1]};
        trial_w = shift_w - {1'b0, dvs_q};
        if (!trial_w[WIDTH]) begin
            rem_d = trial_w[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_d = shift_w[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
    end

    assign stall_o = ~rst & (((state_q == IDLE) & start_i & ~annul_i) | (state_q == BUSY));
    assign ready_o = ready_q;
    assign hi_o    = hi_q;
    assign lo_o    = lo_q;
    assign dz_o    = dz_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            ready_q <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            if (annul_i) begin
                state_q <= IDLE;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start_i) begin
                            if (opb_i == '0) begin
                                lo_q    <= '1;
                                hi_q    <= opa_i;
                                dz_q    <= 1'b1;
                                ready_q <= 1'b1;
                                state_q <= DONE;
                            end else begin
                                quo_q   <= mag_a;
                                dvs_q   <= mag_b;
                                rem_q   <= '0;
                                cnt_q   <= '0;
                                qneg_q  <= (opa_i[WIDTH-1] ^ opb_i[WIDTH-1]) & signed_i;
                                rneg_q  <= opa_i[WIDTH-1] & signed_i;
                                state_q <= BUSY;
                            end
                        end
                    end
                    BUSY: begin
                        rem_q <= rem_d;
                        quo_q <= quo_d;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CNT_W'(WIDTH - 1)) begin
                            lo_q    <= qneg_q ? -quo_d : quo_d;
                            hi_q    <= rneg_q ? -rem_d : rem_d;
                            dz_q    <= 1'b0;
                            ready_q <= 1'b1;
                            cnt_q   <= '0;
                            state_q <= DONE;
                        end
                    end
                    DONE:    state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed bench for div_seq_ctrl: a cycle-count/arithmetic model checked every
// cycle, plus literal expectations for each directed divide.
module tb_div_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0, signed_i = 1'b0, annul_i = 1'b0;
    logic [31:0] opa_i = '0, opb_i = '0;
    logic        stall_o, ready_o, dz_o;
    logic [31:0] hi_o, lo_o;

    int checks = 0;
    int failures = 0;

    div_seq_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .signed_i(signed_i),
        .opa_i(opa_i), .opb_i(opb_i), .annul_i(annul_i),
        .stall_o(stall_o), .ready_o(ready_o), .hi_o(hi_o), .lo_o(lo_o), .dz_o(dz_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void calc(input bit s, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] q, output logic [31:0] r, output bit dz);
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        dz = 1'b0;
        if (b == 0) begin
            q = 32'hFFFFFFFF; r = a; dz = 1'b1;
        end else if (!s) begin
            q = a / b; r = a % b;
        end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
            q = 32'h80000000; r = 0;
        end else begin
            q = sa / sb; r = sa % sb;
        end
    endfunction

    // Model: countdown of busy cycles, pending result applied when it expires.
    int          m_left;
    bit          m_ready, m_dz, p_dz;
    logic [31:0] m_hi, m_lo, p_hi, p_lo;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left = 0; m_ready = 0; m_dz = 0; m_hi = 0; m_lo = 0;
        end else if (annul_i) begin
            m_left = 0; m_ready = 0;
        end else if (m_ready) begin
            m_ready = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_ready = 1; m_hi = p_hi; m_lo = p_lo; m_dz = p_dz;
            end
        end else if (start_i) begin
            calc(signed_i, opa_i, opb_i, p_lo, p_hi, p_dz);
            if (p_dz) begin
                m_ready = 1; m_hi = p_hi; m_lo = p_lo; m_dz = p_dz;
            end else begin
                m_left = 32;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("m_stall", {31'b0, stall_o},
                {31'b0, (m_left > 0) || (!m_ready && m_left == 0 && start_i && !annul_i)});
            chk("m_ready", {31'b0, ready_o}, {31'b0, m_ready});
            chk("m_hi", hi_o, m_hi);
            chk("m_lo", lo_o, m_lo);
            chk("m_dz", {31'b0, dz_o}, {31'b0, m_dz});
        end
    end

    task automatic run_div(input string name, input bit s, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] e_lo, input logic [31:0] e_hi, input bit e_dz, input int e_stalls);
        int stalls;
        bit got;
        stalls = 0;
        got = 0;
        @(posedge clk); #1;
        start_i = 1; signed_i = s; opa_i = a; opb_i = b;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (stall_o) stalls++;
            if (ready_o) begin got = 1; break; end
            @(posedge clk); #1;
            start_i = 0;
            opa_i = $urandom; opb_i = $urandom; signed_i = $urandom_range(0, 1);
        end
        chk({name, "_ready"}, {31'b0, got}, 32'd1);
        chk({name, "_lo"}, lo_o, e_lo);
        chk({name, "_hi"}, hi_o, e_hi);
        chk({name, "_dz"}, {31'b0, dz_o}, {31'b0, e_dz});
        chk({name, "_stalls"}, stalls, e_stalls);
        @(posedge clk); #1;
        start_i = 0;
    endtask

    initial begin
        int cyc, n_rdy, t0, t1;
        bit got;
        #12;
        chk("rst_hi", hi_o, 0);
        chk("rst_lo", lo_o, 0);
        chk("rst_stall", {31'b0, stall_o}, 0);
        chk("rst_ready", {31'b0, ready_o}, 0);
        @(posedge clk); #1;
        rst = 0;

        run_div("udiv", 0, 32'hFFFFFFFF, 32'h10, 32'h0FFFFFFF, 32'hF, 0, 33);
        run_div("sdiv_m7_2", 1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 0, 33);
        run_div("sdiv_7_m2", 1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 0, 33);
        run_div("divz", 0, 32'h1234, 32'h0, 32'hFFFFFFFF, 32'h1234, 1, 1);
        run_div("minneg", 1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0, 0, 33);
        run_div("udiv_100_7", 0, 32'd100, 32'd7, 32'd14, 32'd2, 0, 33);

        // Annul at iteration 10: prior result (14 rem 2) must survive.
        @(posedge clk); #1;
        start_i = 1; signed_i = 1; opa_i = 32'd1000; opb_i = 32'd3;
        @(posedge clk); #1;
        start_i = 0;
        repeat (10) @(posedge clk);
        #1 annul_i = 1;
        @(posedge clk); #1;
        annul_i = 0;
        @(negedge clk);
        chk("annul_stall", {31'b0, stall_o}, 0);
        got = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ready_o) got = 1;
        end
        chk("annul_noready", {31'b0, got}, 0);
        chk("annul_lo", lo_o, 32'd14);
        chk("annul_hi", hi_o, 32'd2);

        // Asynchronous reset mid-BUSY.
        @(posedge clk); #1;
        start_i = 1; signed_i = 0; opa_i = 32'd77; opb_i = 32'd5;
        @(posedge clk); #1;
        start_i = 0;
        repeat (5) @(posedge clk);
        #3 rst = 1;
        #1;
        chk("arst_hi", hi_o, 0);
        chk("arst_lo", lo_o, 0);
        chk("arst_dz", {31'b0, dz_o}, 0);
        chk("arst_stall", {31'b0, stall_o}, 0);
        chk("arst_ready", {31'b0, ready_o}, 0);
        @(posedge clk); #1;
        rst = 0;

        // Back-to-back: start held high, two pulses 34 cycles apart.
        @(posedge clk); #1;
        start_i = 1; signed_i = 0; opa_i = 32'd50; opb_i = 32'd5;
        n_rdy = 0; t0 = 0; t1 = 0;
        for (cyc = 0; cyc < 80 && n_rdy < 2; cyc++) begin
            @(negedge clk);
            if (ready_o) begin
                if (n_rdy == 0) t0 = cyc; else t1 = cyc;
                n_rdy++;
            end
            @(posedge clk); #1;
            if (n_rdy == 2) start_i = 0;
        end
        chk("b2b_first", t0, 33);
        chk("b2b_gap", t1 - t0, 34);
        chk("b2b_lo", lo_o, 32'd10);
        chk("b2b_hi", hi_o, 32'd0);
        repeat (40) @(negedge clk) if (ready_o) n_rdy++;
        chk("b2b_count", n_rdy, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
